// File: rtl/time_counter.sv
// MM:SS stopwatch with a start/stop/clear FSM, a one-second prescaler and BCD
// digits advanced through CSA incrementers. Define TIME_COUNTER_LAP_EN for lap freeze.

// W-bit adder (a + b + ci) used as the per-digit incrementer.
module time_counter_csa #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co
);

   always_comb begin
      logic c;
      // NOTE: always_comb uses blocking '=' and assigns every output first, so no latch is inferred.
      s = '0;
      c = ci;
      for (int i = 0; i < W; i++) begin
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      co = c;
   end

endmodule

module time_counter #(
   parameter int TICKS_PER_SEC = 100000000,
   parameter int DIGIT_WIDTH   = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start_stop,
   input  logic                   clear,
   input  logic                   lap,
   output logic [DIGIT_WIDTH-1:0] sec_ones,
   output logic [DIGIT_WIDTH-1:0] sec_tens,
   output logic [DIGIT_WIDTH-1:0] min_ones,
   output logic [DIGIT_WIDTH-1:0] min_tens,
   output logic                   running,
   output logic                   wrap
);

   localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

   // Digit order: 0 = sec_ones, 1 = sec_tens, 2 = min_ones, 3 = min_tens.
   localparam logic [3:0][DIGIT_WIDTH-1:0] DIGIT_MAX = {
      DIGIT_WIDTH'(5), DIGIT_WIDTH'(9), DIGIT_WIDTH'(5), DIGIT_WIDTH'(9)
   };

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   state_t                        state_q, state_d;
   logic [PW-1:0]                 presc_q, presc_d;
   logic [3:0][DIGIT_WIDTH-1:0]   digit_q, digit_d;
   logic                          wrap_q, wrap_d;

   logic                          count_en;
   logic [4:0]                    carry;
   logic [3:0]                    at_max;
   logic [3:0]                    inc_co;
   logic [3:0][DIGIT_WIDTH-1:0]   inc_sum;

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = (state_q == RUN) ? RUN : IDLE;
      end else if (start_stop) begin
         unique case (state_q)
            IDLE:    state_d = RUN;
            RUN:     state_d = PAUSE;
            PAUSE:   state_d = RUN;
            default: state_d = IDLE;
         endcase
      end
   end

   // The pausing edge does not consume a prescaler count, so a resumed second
   // completes after exactly the cycles it had left.
   assign count_en = (state_q == RUN) && !clear && !start_stop;

   // ---------------------------------------------------------------- prescaler
   always_comb begin
      presc_d = presc_q;
      if (state_q == IDLE || clear) begin
         presc_d = '0;
      end else if (count_en) begin
         presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
      end
   end

   // ---------------------------------------------------------------- digits
   for (genvar i = 0; i < 4; i++) begin : g_digit
      time_counter_csa #(
         .W (DIGIT_WIDTH)
      ) u_csa (
         .a  (digit_q[i]),
         .b  ({DIGIT_WIDTH{1'b0}}),
         .ci (1'b1),
         .s  (inc_sum[i]),
         .co (inc_co[i])
      );
      assign at_max[i] = (digit_q[i] >= DIGIT_MAX[i]);
   end

   always_comb begin
      carry    = '0;
      carry[0] = count_en && (presc_q == PRESC_MAX);
      for (int i = 0; i < 4; i++) begin
         carry[i+1] = carry[i] & at_max[i];
      end
   end

   always_comb begin
      digit_d = digit_q;
      for (int i = 0; i < 4; i++) begin
         if (clear) begin
            digit_d[i] = '0;
         end else if (carry[i]) begin
            // Any digit at or beyond its limit returns to 0, keeping the digits BCD.
            digit_d[i] = (at_max[i] || inc_co[i]) ? '0 : inc_sum[i];
         end
      end
   end

   assign wrap_d = carry[4];

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
      if (reset) begin
         state_q <= IDLE;
         presc_q <= '0;
         digit_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         digit_q <= digit_d;
         wrap_q  <= wrap_d;
      end
   end

   assign running = (state_q == RUN);
   assign wrap    = wrap_q;

   // ---------------------------------------------------------------- display
`ifdef TIME_COUNTER_LAP_EN
   logic                        freeze_q, freeze_d;
   logic [3:0][DIGIT_WIDTH-1:0] hold_q, hold_d;

   always_comb begin
      freeze_d = freeze_q;
      hold_d   = hold_q;
      if (clear || state_d == IDLE) begin
         freeze_d = 1'b0;
      end else if (lap && state_q == RUN) begin
         freeze_d = !freeze_q;
         if (!freeze_q) begin
            hold_d = digit_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: the held display is reset too, so nothing stale can ever be shown.
      if (reset) begin
         freeze_q <= 1'b0;
         hold_q   <= '0;
      end else begin
         freeze_q <= freeze_d;
         hold_q   <= hold_d;
      end
   end

   assign sec_ones = freeze_q ? hold_q[0] : digit_q[0];
   assign sec_tens = freeze_q ? hold_q[1] : digit_q[1];
   assign min_ones = freeze_q ? hold_q[2] : digit_q[2];
   assign min_tens = freeze_q ? hold_q[3] : digit_q[3];
`else
   logic lap_unused;
   assign lap_unused = lap;

   assign sec_ones = digit_q[0];
   assign sec_tens = digit_q[1];
   assign min_ones = digit_q[2];
   assign min_tens = digit_q[3];
`endif

endmodule

// File: tb/tb_time_counter.sv
// Self-checking bench for time_counter (TICKS_PER_SEC=4): directed steps then random
// pulses, all compared every cycle against a seconds-based reference model.
module tb_time_counter;

   localparam int T = 4;
`ifdef TIME_COUNTER_LAP_EN
   localparam bit LAP_EN = 1'b1;
`else
   localparam bit LAP_EN = 1'b0;
`endif

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start_stop = 1'b0;
   logic       clear = 1'b0;
   logic       lap = 1'b0;
   logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
   logic       running, wrap;

   int total = 0;
   int bad   = 0;

   // Reference model: mode, elapsed seconds and RUN cycles into the current second.
   int m_mode = M_IDLE;
   int m_secs = 0;
   int m_sub  = 0;
   bit m_wrap = 1'b0;
   bit m_frozen = 1'b0;
   int m_held = 0;

   time_counter #(
      .TICKS_PER_SEC (T),
      .DIGIT_WIDTH   (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start_stop (start_stop),
      .clear      (clear),
      .lap        (lap),
      .sec_ones   (sec_ones),
      .sec_tens   (sec_tens),
      .min_ones   (min_ones),
      .min_tens   (min_tens),
      .running    (running),
      .wrap       (wrap)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input bit rst, input bit ss, input bit clr, input bit lp);
      int old_mode;
      int old_secs;
      old_mode = m_mode;
      old_secs = m_secs;
      m_wrap   = 1'b0;
      if (rst) begin
         m_mode   = M_IDLE;
         m_secs   = 0;
         m_sub    = 0;
         m_frozen = 1'b0;
         m_held   = 0;
      end else begin
         if (clr) begin
            m_secs = 0;
            m_sub  = 0;
            m_mode = (old_mode == M_RUN) ? M_RUN : M_IDLE;
         end else if (old_mode == M_RUN && ss) begin
            m_mode = M_PAUSE;
         end else if (old_mode == M_RUN) begin
            m_sub++;
            if (m_sub == T) begin
               m_sub  = 0;
               m_secs = (m_secs + 1) % 3600;
               m_wrap = (m_secs == 0);
            end
         end else if (ss) begin
            m_mode = M_RUN;
         end
         if (LAP_EN) begin
            if (clr || m_mode == M_IDLE) begin
               m_frozen = 1'b0;
            end else if (lp && old_mode == M_RUN) begin
               if (!m_frozen) m_held = old_secs;
               m_frozen = !m_frozen;
            end
         end
      end
   endtask

   function automatic logic [31:0] exp_digits();
      int shown;
      int mm;
      int sc;
      shown = m_frozen ? m_held : m_secs;
      mm = shown / 60;
      sc = shown % 60;
      return {16'h0, 4'(mm / 10), 4'(mm % 10), 4'(sc / 10), 4'(sc % 10)};
   endfunction

   task automatic cycle(input bit rst, input bit ss, input bit clr, input bit lp);
      reset      = rst;
      start_stop = ss;
      clear      = clr;
      lap        = lp;
      @(posedge clk);
      model_step(rst, ss, clr, lp);
      #1;
      reset      = 1'b0;
      start_stop = 1'b0;
      clear      = 1'b0;
      lap        = 1'b0;
      check("digits", {16'h0, min_tens, min_ones, sec_tens, sec_ones}, exp_digits());
      check("running", {31'h0, running}, {31'h0, m_mode == M_RUN});
      check("wrap", {31'h0, wrap}, {31'h0, m_wrap});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      // Reset state
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      check("reset_running", {31'h0, running}, 32'd0);
      check("reset_digits", {16'h0, min_tens, min_ones, sec_tens, sec_ones}, 32'h0);

      // First second takes exactly T cycles
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      check("start_running", {31'h0, running}, 32'd1);
      run(T - 1);
      check("before_first_sec", {28'h0, sec_ones}, 32'd0);
      run(1);
      check("first_sec", {28'h0, sec_ones}, 32'd1);

      // sec_ones 9 -> 0 carries into sec_tens
      run(9 * T);
      check("sec_carry", {24'h0, sec_tens, sec_ones}, 32'h10);

      // 59:58 -> 59:59 -> 00:00 with a one-cycle wrap pulse
      run(3588 * T);
      check("at_5958", {16'h0, min_tens, min_ones, sec_tens, sec_ones}, 32'h5958);
      run(T);
      check("at_5959", {16'h0, min_tens, min_ones, sec_tens, sec_ones}, 32'h5959);
      run(T - 1);
      check("wrap_not_early", {31'h0, wrap}, 32'd0);
      run(1);
      check("wrap_pulse", {31'h0, wrap}, 32'd1);
      check("wrap_digits", {16'h0, min_tens, min_ones, sec_tens, sec_ones}, 32'h0);
      run(1);
      check("wrap_one_cycle", {31'h0, wrap}, 32'd0);
      check("wrap_running", {31'h0, running}, 32'd1);

      // Pause after 2 prescaler counts, resume, finish the second in 2 cycles
      run(1);
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      check("paused", {31'h0, running}, 32'd0);
      run(10);
      check("pause_hold", {28'h0, sec_ones}, 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      run(1);
      check("resume_partial", {28'h0, sec_ones}, 32'd0);
      run(1);
      check("resume_tick", {28'h0, sec_ones}, 32'd1);

      // clear + start_stop in RUN at 00:07, then clear in PAUSE
      run(6 * T);
      check("at_0007", {28'h0, sec_ones}, 32'd7);
      cycle(1'b0, 1'b1, 1'b1, 1'b0);
      check("clear_run_digits", {16'h0, min_tens, min_ones, sec_tens, sec_ones}, 32'h0);
      check("clear_run_running", {31'h0, running}, 32'd1);
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      check("clear_pause_idle", {31'h0, running}, 32'd0);

      // Reset at prescaler = T-1 discards the partial second
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      run(T - 1);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      check("midsec_reset_digits", {16'h0, min_tens, min_ones, sec_tens, sec_ones}, 32'h0);
      check("midsec_reset_running", {31'h0, running}, 32'd0);
      run(T);
      check("no_increment_after_reset", {28'h0, sec_ones}, 32'd0);

      // Lap freeze (no effect without the feature)
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      run(3 * T);
      check("at_0003", {28'h0, sec_ones}, 32'd3);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      run(8);
      check("lap_hold", {28'h0, sec_ones}, LAP_EN ? 32'd3 : 32'd5);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      check("lap_release", {28'h0, sec_ones}, 32'd5);

      // Random pulses against the model
      for (int i = 0; i < 3000; i++) begin
         bit r;
         bit s;
         bit c;
         bit l;
         r = ($urandom_range(199) == 0);
         s = ($urandom_range(9) == 0);
         c = ($urandom_range(39) == 0);
         l = ($urandom_range(7) == 0);
         cycle(r, s, c, l);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/time_counter.md
TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 The block SHALL have parameter TICKS_PER_SEC, default 100000000, giving clk cycles per counted second (legal range 2..2^27).
REQ-002 The block SHALL have parameter DIGIT_WIDTH, default 4, giving the width of each BCD digit fed to the internal CSA incrementers.
REQ-003 The block SHALL have port clk, input, 1, the single system clock (all logic on its rising edge).
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port start_stop, input, 1, a one-cycle pulse that toggles counting.
REQ-006 The block SHALL have port clear, input, 1, a one-cycle pulse that zeroes the time.
REQ-007 The block SHALL have port lap, input, 1, a one-cycle pulse that toggles the display freeze (used only with the macro defined).
REQ-008 The block SHALL have ports sec_ones, sec_tens, min_ones and min_tens, each output, DIGIT_WIDTH, the displayed BCD time MM:SS.
REQ-009 The block SHALL have port running, output, 1, high while in RUN.
REQ-010 The block SHALL have port wrap, output, 1, a one-cycle pulse on the 59:59 to 00:00 rollover.

Function
REQ-011 FSM states SHALL be IDLE, RUN and PAUSE.
REQ-012 Transitions SHALL be: IDLE -start_stop-> RUN; RUN -start_stop-> PAUSE; PAUSE -start_stop-> RUN; any state -clear-> IDLE, except RUN -clear-> RUN.
REQ-013 When clear and start_stop are asserted in the same cycle, clear SHALL win and start_stop SHALL be ignored.
REQ-014 The prescaler SHALL count 0..TICKS_PER_SEC-1 only in RUN, hold in PAUSE, and be forced to 0 in IDLE and on clear.
REQ-015 On the edge where the prescaler equals TICKS_PER_SEC-1 in RUN, the prescaler SHALL go to 0 and the time SHALL advance by one second, visible on the outputs after that same edge.
REQ-016 The first second after IDLE->RUN SHALL take exactly TICKS_PER_SEC cycles; PAUSE->RUN SHALL resume the partial second without loss.
REQ-017 Digit increment SHALL use CSA instances with ci=1, b=0, with carries as follows:
- sec_ones 9->0 carries into sec_tens;
- sec_tens 5->0 carries into min_ones;
- min_ones 9->0 carries into min_tens;
- min_tens 5->0 wraps.
REQ-018 At 59:59 plus one second, all digits SHALL become 0, wrap SHALL pulse high for exactly one cycle, and the FSM SHALL stay in RUN.
REQ-019 clear in RUN SHALL zero the digits and the prescaler on the next edge and keep counting from 00:00.
REQ-020 Digits SHALL never hold non-BCD values (sec_tens/min_tens never exceed 5; ones digits never exceed 9).

Reset
REQ-021 reset SHALL override all inputs and, on the next rising edge, put the FSM in IDLE, the prescaler at 0, all digits at 0, running at 0, wrap at 0 and the lap freeze off.
REQ-022 reset asserted mid-second in RUN SHALL discard the partial second; there SHALL be no asynchronous path from reset to any output.

Configuration
REQ-023 With macro TIME_COUNTER_LAP_EN defined:
- lap in RUN SHALL toggle the freeze;
- while frozen, the digit outputs SHALL hold their values from the freeze edge while internal counting continues;
- unfreezing SHALL show the live time on the next edge;
- clear or entering IDLE SHALL cancel the freeze.
REQ-024 Without TIME_COUNTER_LAP_EN, lap SHALL be ignored, no freeze register SHALL exist, and the outputs SHALL always show the live time.

Verification (TICKS_PER_SEC=4)
REQ-025 Reset, then pulse start_stop -> running=1 next cycle; sec_ones=1 exactly 4 cycles later; sec_ones=9 -> sec_tens=1, sec_ones=0.
REQ-026 Count in RUN from 59:58 -> 59:59, then 00:00 with a wrap pulse of exactly 1 cycle; running stays 1.
REQ-027 Pulse start_stop after 2 prescaler cycles (PAUSE), wait 10 cycles, pulse start_stop again -> next increment after 2 more cycles; digits unchanged during PAUSE.
REQ-028 Assert clear and start_stop together in RUN at 00:07 -> 00:00, running=1; clear in PAUSE -> IDLE, running=0.
REQ-029 Assert reset at prescaler=3 in RUN -> next edge all digits 0, running=0, wrap=0; no increment occurs.
REQ-030 With TIME_COUNTER_LAP_EN: lap at 00:03, wait 8 cycles -> outputs hold 00:03; lap again -> outputs show 00:05. Without the macro, lap has no effect.
